// File: rtl/newton_pkg.sv
// Shared definitions for the newton reciprocal-step datapath:
// signed-digit encoding and digit-to-value conversion.
package newton_pkg;

    // Digit encoding {plus, minus}: value = plus - minus.
    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_NEG  = 2'b01;
    localparam logic [1:0] DIG_ZERO = 2'b00;

    typedef logic signed [1:0] sdig_t;

    function automatic sdig_t digit_val(input logic [1:0] d);
        sdig_t v;
        case (d)
            DIG_POS: v = 2'sd1;
            DIG_NEG: v = -2'sd1;
            default: v = 2'sd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/newton_digit_acc.sv
// Online signed-digit to two's-complement accumulator, one operand, MSD first.
// Framing is supplied by the parent through last_i; this block holds no counter.
module newton_digit_acc
    import newton_pkg::*;
#(
    parameter int unsigned AccW = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   last_i,
    input  logic [1:0]             digit_i,
    output logic signed [AccW-1:0] final_o
);

    logic signed [AccW-1:0] acc_q, acc_d;
    logic signed [AccW-1:0] dig_ext;
    sdig_t                  dig_v;

    assign dig_v   = digit_val(digit_i);
    assign dig_ext = {{(AccW-2){dig_v[1]}}, dig_v};

    // Value of the frame including the digit currently presented.
    assign final_o = (acc_q <<< 1) + dig_ext;

    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = last_i ? '0 : final_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/newton.sv
// One Newton-Raphson reciprocal step x1 = x0 * (2 - b * x0) on serial signed-digit
// operands; result is registered two cycles after the last digit is accepted.
module newton
    import newton_pkg::*;
#(
    parameter int unsigned NDIG = 8
) (
    input  logic            clk,
    input  logic            asyn_reset,
    input  logic [1:0]      x_zero,
    input  logic [1:0]      b_value,
    input  logic            enable,
    output logic [NDIG+3:0] x_out,
    output logic            done
);

    localparam int unsigned AccW  = NDIG + 2;
    localparam int unsigned TW    = NDIG + 4;
    localparam int unsigned ProdW = 2 * NDIG + 4;
    localparam int unsigned CntW  = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic signed [TW-1:0] TwoFix = TW'(2 << NDIG);

    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   last_digit;
    logic                   load;

    logic signed [AccW-1:0] x_fin, b_fin;
    logic signed [AccW-1:0] x_op_q, b_op_q;
    logic                   op_vld_q;

    logic signed [TW-1:0]   p_val;
    logic signed [TW-1:0]   t_d, t_q;
    logic signed [AccW-1:0] x_st_q;
    logic                   st1_vld_q;

    logic signed [TW-1:0]   x_out_d, x_out_q;
    logic                   done_q;

    logic signed [ProdW-1:0] b_ext, x_ext, xs_ext, t_ext;

    assign last_digit = (cnt_q == CntW'(NDIG - 1));
    assign load       = enable & last_digit;

    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = last_digit ? '0 : cnt_q + CntW'(1);
        end
    end

    newton_digit_acc #(
        .AccW (AccW)
    ) u_acc_x (
        .clk_i   (clk),
        .rst_ni  (asyn_reset),
        .en_i    (enable),
        .last_i  (last_digit),
        .digit_i (x_zero),
        .final_o (x_fin)
    );

    newton_digit_acc #(
        .AccW (AccW)
    ) u_acc_b (
        .clk_i   (clk),
        .rst_ni  (asyn_reset),
        .en_i    (enable),
        .last_i  (last_digit),
        .digit_i (b_value),
        .final_o (b_fin)
    );

    // Full-width signed products; the arithmetic shift gives floor division.
    assign b_ext  = {{(ProdW-AccW){b_op_q[AccW-1]}}, b_op_q};
    assign x_ext  = {{(ProdW-AccW){x_op_q[AccW-1]}}, x_op_q};
    assign xs_ext = {{(ProdW-AccW){x_st_q[AccW-1]}}, x_st_q};
    assign t_ext  = {{(ProdW-TW){t_q[TW-1]}}, t_q};

    assign p_val   = TW'((b_ext * x_ext) >>> NDIG);
    assign t_d     = TwoFix - p_val;
    assign x_out_d = TW'((xs_ext * t_ext) >>> NDIG);

    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            cnt_q     <= '0;
            x_op_q    <= '0;
            b_op_q    <= '0;
            op_vld_q  <= 1'b0;
            t_q       <= '0;
            x_st_q    <= '0;
            st1_vld_q <= 1'b0;
            x_out_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (load) begin
                x_op_q <= x_fin;
                b_op_q <= b_fin;
            end
            op_vld_q <= load;
            if (op_vld_q) begin
                t_q    <= t_d;
                x_st_q <= x_op_q;
            end
            st1_vld_q <= op_vld_q;
            if (st1_vld_q) begin
                x_out_q <= x_out_d;
            end
            done_q <= st1_vld_q;
        end
    end

    assign x_out = x_out_q;
    assign done  = done_q;

endmodule

// File: tb/tb_newton.sv
// Self-checking bench for newton: digit-level reference model plus directed
// literal checks and randomized frames with stalls and resets.
module tb_newton;

    localparam int NDIG = 8;
    localparam int XW   = NDIG + 4;
    localparam int DEN  = 1 << NDIG;

    logic          clk = 1'b0;
    logic          asyn_reset = 1'b0;
    logic [1:0]    x_zero = 2'b00;
    logic [1:0]    b_value = 2'b00;
    logic          enable = 1'b0;
    logic [XW-1:0] x_out;
    logic          done;

    newton #(
        .NDIG (NDIG)
    ) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .x_zero     (x_zero),
        .b_value    (b_value),
        .enable     (enable),
        .x_out      (x_out),
        .done       (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        logic [XW-1:0] val;
    } res_t;

    typedef struct {
        int            e;
        logic [XW-1:0] v;
    } log_t;

    res_t pend[$];
    log_t done_log[$];
    int   edge_n = 0;
    int   mcnt = 0;
    int   mx[NDIG];
    int   mb[NDIG];
    int   fx, fb, fp, ft, fr;
    logic [XW-1:0] exp_x = '0;
    logic          exp_done;

    function automatic int fdiv(input int a);
        if (a >= 0) return a / DEN;
        return -((-a + DEN - 1) / DEN);
    endfunction

    function automatic int dv(input logic [1:0] d);
        return int'(d[1]) - int'(d[0]);
    endfunction

    always @(posedge clk) begin
        edge_n++;
        if (!asyn_reset) begin
            mcnt = 0;
        end else if (enable) begin
            mx[mcnt] = dv(x_zero);
            mb[mcnt] = dv(b_value);
            mcnt++;
            if (mcnt == NDIG) begin
                fx = 0;
                fb = 0;
                for (int i = 0; i < NDIG; i++) begin
                    fx += mx[i] * (1 << (NDIG - 1 - i));
                    fb += mb[i] * (1 << (NDIG - 1 - i));
                end
                fp = fdiv(fb * fx);
                ft = 2 * DEN - fp;
                fr = fdiv(fx * ft);
                pend.push_back('{edge_n + 2, XW'(fr)});
                mcnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!asyn_reset) begin
            pend.delete();
            exp_x = '0;
            check("reset_done", int'(done), 0);
            check("reset_x_out", int'(x_out), 0);
        end else begin
            exp_done = 1'b0;
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                exp_x    = pend[0].val;
                exp_done = 1'b1;
                void'(pend.pop_front());
            end
            check("done", int'(done), int'(exp_done));
            check("x_out", int'(x_out), int'(exp_x));
            if (done) done_log.push_back('{edge_n, x_out});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [1:0] xd, input logic [1:0] bd, input logic en);
        x_zero  = xd;
        b_value = bd;
        enable  = en;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'($urandom), 2'($urandom), 1'b0);
    endtask

    task automatic send_frame(input logic [2*NDIG-1:0] xf, input logic [2*NDIG-1:0] bf,
                              input int ndig, input int gap_at, input int gap_len,
                              output int s, output int l);
        s = -1;
        l = -1;
        for (int i = 0; i < ndig; i++) begin
            if (i == gap_at) idle(gap_len);
            drive(xf[2*(NDIG-1-i) +: 2], bf[2*(NDIG-1-i) +: 2], 1'b1);
            if (i == 0) s = edge_n;
            l = edge_n;
        end
        enable = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        asyn_reset = 1'b0;
        enable     = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        asyn_reset = 1'b1;
    endtask

    task automatic expect_one(input string name, input logic [XW-1:0] lit, input int l);
        check({name, "_count"}, done_log.size(), 1);
        if (done_log.size() >= 1) begin
            check({name, "_val"}, int'(done_log[0].v), int'(lit));
            check({name, "_lat"}, done_log[0].e - l, 2);
        end
    endtask

    initial begin
        int s, l, s2, l2;
        logic [2*NDIG-1:0] rx, rb;

        repeat (3) @(posedge clk);
        #1;
        asyn_reset = 1'b1;
        idle(2);

        // b = x0 = +0.5
        done_log.delete();
        send_frame(16'h8000, 16'h8000, NDIG, -1, 0, s, l);
        idle(4);
        expect_one("pos_half", 12'h0E0, l);

        // b = x0 = -0.5
        done_log.delete();
        send_frame(16'h4000, 16'h4000, NDIG, -1, 0, s, l);
        idle(4);
        expect_one("neg_half", 12'hF20, l);

        // b = 0 (mixed zero codes), x0 = 0.25 in redundant form
        done_log.delete();
        send_frame(16'h9000, 16'hC3C3, NDIG, -1, 0, s, l);
        idle(4);
        expect_one("b_zero", 12'h080, l);

        // floor of a negative product
        done_log.delete();
        send_frame(16'h0001, 16'h0002, NDIG, -1, 0, s, l);
        idle(4);
        expect_one("lsb_neg", 12'hFFD, l);

        done_log.delete();
        send_frame(16'h0002, 16'h0002, NDIG, -1, 0, s, l);
        idle(4);
        expect_one("lsb_pos", 12'h002, l);

        // back-to-back frames
        done_log.delete();
        send_frame(16'h8000, 16'h8000, NDIG, -1, 0, s, l);
        send_frame(16'h4000, 16'h4000, NDIG, -1, 0, s2, l2);
        idle(5);
        check("b2b_count", done_log.size(), 2);
        if (done_log.size() >= 2) begin
            check("b2b_spacing", done_log[1].e - done_log[0].e, NDIG);
            check("b2b_val0", int'(done_log[0].v), 12'h0E0);
            check("b2b_val1", int'(done_log[1].v), 12'hF20);
        end

        // 3-cycle stall mid-frame
        done_log.delete();
        send_frame(16'h8000, 16'h8000, NDIG, 4, 3, s, l);
        idle(4);
        check("stall_count", done_log.size(), 1);
        if (done_log.size() >= 1) begin
            check("stall_delay", done_log[0].e - s, NDIG + 1 + 3);
            check("stall_val", int'(done_log[0].v), 12'h0E0);
        end

        // reset after digit 5, then a complete frame
        done_log.delete();
        send_frame(16'hAAAA, 16'h5555, 5, -1, 0, s, l);
        do_reset(2);
        send_frame(16'h9000, 16'hC3C3, NDIG, -1, 0, s, l);
        idle(4);
        expect_one("rst_mid", 12'h080, l);

        // reset while stage 1 is pending cancels the result
        done_log.delete();
        send_frame(16'h8000, 16'h8000, NDIG, -1, 0, s, l);
        do_reset(1);
        idle(4);
        check("rst_stage_count", done_log.size(), 0);

        // randomized frames against the model
        for (int n = 0; n < 60; n++) begin
            rx = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                send_frame(rx, rb, $urandom_range(1, NDIG - 1), -1, 0, s, l);
                do_reset($urandom_range(1, 3));
            end else if ($urandom_range(0, 1) == 0) begin
                send_frame(rx, rb, NDIG, -1, 0, s, l);
            end else begin
                send_frame(rx, rb, NDIG, $urandom_range(1, NDIG - 1), $urandom_range(1, 3),
                           s, l);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
        end
        idle(5);
        check("pending_drained", pend.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/newton.md
NEWTON -- requirements
Module: newton

Interface
REQ-001 The block SHALL expose parameter NDIG, default 8, meaning the number of signed digits per operand frame (all widths below derive from it).
REQ-002 The block SHALL expose ports, clock and reset first: clk input 1 system clock (rising edge).
REQ-003 asyn_reset input 1: the single reset, asynchronous and active-low.
REQ-004 x_zero input 2: current digit of the initial estimate x0, MSD first.
REQ-005 b_value input 2: current digit of the operand b, MSD first.
REQ-006 enable input 1: when high, the digit pair on x_zero/b_value is accepted at the rising clk edge.
REQ-007 x_out output NDIG+4: signed two's-complement result x1, NDIG fractional bits.
REQ-008 done output 1: one-cycle pulse marking a new x_out value.

Function
REQ-009 Digit encoding SHALL be {plus,minus}: value = bit1 - bit0, so 2'b10=+1, 2'b01=-1, 2'b00 and 2'b11=0.
REQ-010 Digit i of a frame (i=1..NDIG) SHALL have weight 2^-i, so operands lie in (-1,1) with redundant representations allowed.
REQ-011 Per operand, an NDIG+2-bit signed accumulator SHALL update acc <= 2*acc + digit on each accepted digit, starting from 0 at frame start.
REQ-012 A digit counter SHALL count accepted digits 0..NDIG-1; enable low SHALL stall counter and accumulators with no other effect.
REQ-013 On the edge accepting digit NDIG: final X = 2*accx+dx and B = 2*accb+db SHALL load into operand registers, accumulators clear and the counter wraps to 0, so the next frame may start on the following cycle.
REQ-014 Stage 1, edge after operand load: P = floor(B*X / 2^NDIG) (arithmetic right shift of the full product), T = 2*2^NDIG - P, registered with a copy of X.
REQ-015 Stage 2, next edge: x_out <= floor(X*T / 2^NDIG) (arithmetic right shift), done <= 1; this is one Newton-Raphson reciprocal step x1 = x0*(2 - b*x0).
REQ-016 Latency SHALL be exactly 2 cycles: done is high during the cycle after the second edge following acceptance of digit NDIG, and low otherwise.
REQ-017 Intermediate widths SHALL be wide enough that no overflow occurs for any input (|x1| < 3 fits NDIG+4 bits).
REQ-018 x_out SHALL hold its value until the next done.
REQ-019 Stage 1 and stage 2 SHALL run regardless of enable, so a frame's result emerges even if enable drops afterwards.

Reset
REQ-020 While asyn_reset is low, accumulators, counter, operand, stage and x_out registers SHALL be 0 and done 0, asynchronously.
REQ-021 Reset mid-frame SHALL discard partial digits; the first accepted digit after release is digit 1 of a new frame.
REQ-022 Reset during stage 1/2 SHALL cancel the pending result; no done pulse follows.

Structure
REQ-023 A shared package SHALL hold the digit encoding constants (DIG_POS, DIG_NEG, DIG_ZERO) and a digit-to-signed-value conversion function.
REQ-024 One sub-module, newton_digit_acc (counter-free online-to-two's-complement accumulator), SHALL be instantiated once per operand.

Verification
REQ-025 b=+0.5 (10 then 7x00), x0=+0.5 -> done 2 cycles after digit 8, x_out = 12'h0E0 (0.875).
REQ-026 b=-0.5 (01 then 00s), x0=-0.5 -> x_out = 12'hF20 (-0.875).
REQ-027 b=0 (all 00/11 mixed), x0 digits 10,01,00... (=0.25, redundant) -> x_out = 12'h080 (0.5).
REQ-028 b=2^-8, x0=-2^-8 (digit 8 only) -> P=-1 by floor, T=513, x_out = 12'hFFD; b=x0=2^-8 -> x_out = 12'h002.
REQ-029 Two back-to-back frames with enable held high -> two done pulses exactly 8 cycles apart, correct values each; enable deasserted 3 cycles mid-frame -> same result, done delayed by 3.
REQ-030 asyn_reset asserted after digit 5, then a full frame -> no spurious done; result matches the second frame only.
